// File: rtl/soc_system_pio_status_in.sv
// Avalon-MM input PIO returning FPGA-side status to the HPS.
// Synchronises in_port, exposes the live value, captures selected edges into a
// W1C sticky register and raises a level irq from captured & masked bits.
module soc_system_pio_status_in #(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned EDGE_TYPE   = 0,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int unsigned CNT_W = $clog2(SYNC_STAGES + 2);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_d [SYNC_STAGES];
    logic [WIDTH-1:0] sync_val;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic [CNT_W-1:0] blank_cnt_q, blank_cnt_d;
    logic [31:0]      readdata_q, readdata_d;
    logic [WIDTH-1:0] edge_v;
    logic [WIDTH-1:0] clr;
    logic             blanking;
    logic             wr_en;
    logic [31:0]      unused_writedata;

    assign sync_val = sync_q[SYNC_STAGES-1];
    assign readdata = readdata_q;

    // Upper writedata bits beyond WIDTH carry no meaning for this register set.
    always_comb unused_writedata = writedata;

    // Synchroniser shift, prev tracking and post-reset blanking counter.
    always_comb begin
        sync_d[0] = in_port;
        for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        prev_d      = sync_val;
        blanking    = (blank_cnt_q < BLANK_LAST);
        blank_cnt_d = blanking ? blank_cnt_q + 1'b1 : blank_cnt_q;
    end

    // Edge vector per EDGE_TYPE, suppressed while the synchroniser refills.
    always_comb begin
        edge_v = '0;
        case (EDGE_TYPE)
            0:       edge_v = sync_val & ~prev_q;
            1:       edge_v = ~sync_val & prev_q;
            default: edge_v = sync_val ^ prev_q;
        endcase
        if (blanking) begin
            edge_v = '0;
        end
    end

    // Register writes: mask load and W1C capture, with a same-cycle edge winning.
    always_comb begin
        wr_en  = chipselect && !write_n;
        clr    = '0;
        mask_d = mask_q;
        if (wr_en && address == 2'd3) begin
            clr = writedata[WIDTH-1:0];
        end
        if (wr_en && address == 2'd2) begin
            mask_d = writedata[WIDTH-1:0];
        end
        cap_d = (cap_q & ~clr) | edge_v;
    end

    // Read mux, registered every cycle regardless of chipselect.
    always_comb begin
        readdata_d = '0;
        case (address)
            2'd0:    readdata_d[WIDTH-1:0] = sync_val;
            2'd2:    readdata_d[WIDTH-1:0] = mask_q;
            2'd3:    readdata_d[WIDTH-1:0] = cap_q;
            default: readdata_d = '0;
        endcase
    end

    // Level interrupt straight from the capture and mask registers.
    always_comb irq = |(cap_q & mask_q);

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            prev_q      <= '0;
            mask_q      <= '0;
            cap_q       <= '0;
            blank_cnt_q <= '0;
            readdata_q  <= '0;
        end else begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            prev_q      <= prev_d;
            mask_q      <= mask_d;
            cap_q       <= cap_d;
            blank_cnt_q <= blank_cnt_d;
            readdata_q  <= readdata_d;
        end
    end

endmodule

// File: doc/soc_system_pio_status_in.md
Name: soc_system_pio_status_in

Overview:
- Avalon-MM slave input PIO that returns FPGA-side status bits to the HPS. It is the reading direction for the instruction output PIO: the HPS writes an opcode out through that PIO and reads the accelerator's status back through this one.
- Synchronises `in_port` into `clk`, exposes the live value, and latches selected edges into a sticky edge-capture register. The HPS clears that register by writing 1s.
- Drives a level `irq` from the captured edges gated by an interrupt mask.

Parameters:
- WIDTH, 4, number of status bits on `in_port` (1..32).
- EDGE_TYPE, 0, edge to capture: 0 = rising, 1 = falling, 2 = any.
- SYNC_STAGES, 2, flip-flop stages in the input synchroniser (2..4).

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- address  in  2  register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- in_port  in  WIDTH  asynchronous status inputs.
- readdata  out  32  read data, registered, read latency 1.
- irq  out  1  level interrupt.

Behaviour:
- Clock and reset: one clock, `clk`. Reset is synchronous and active-high, port `reset`, sampled on the rising edge of `clk`.
- Register map (word addresses):
  - 0 DATA: read returns the synchronised input value. Writes are ignored.
  - 1: reads 0. Writes are ignored.
  - 2 IRQ_MASK: read/write, WIDTH bits.
  - 3 EDGE_CAPTURE: read returns the captured bits. A write clears each bit where `writedata` is 1 (W1C).
- Width rule: reads zero-extend WIDTH-bit values to 32 bits. `writedata[31:WIDTH]` is ignored.
- Synchroniser and edge detect:
  - `in_port` passes through a SYNC_STAGES-deep flop chain to give `sync_val`.
  - A `prev_val` register holds `sync_val` delayed by one cycle.
  - Edge vector:
    - rising = `sync_val & ~prev_val`
    - falling = `~sync_val & prev_val`
    - any = the XOR of the two.
  - Latency: a change on `in_port` shows in DATA after SYNC_STAGES cycles. The matching EDGE_CAPTURE bit sets one cycle after that.
- Capture: for each bit, `cap_next = (cap & ~clr) | edge`. Here `clr` is the W1C mask, active only on a write to address 3.
  - If an edge and a clear hit the same bit in the same cycle, the set wins and the bit reads 1 afterwards.
- Interrupt: `irq = |(cap & mask)`, combinational from registers. There is no extra cycle of latency beyond the capture register.
  - Writing the mask takes effect on `irq` in the cycle after the write.
- Post-reset guard: a counter blanks edge detection for SYNC_STAGES+1 cycles after `reset` deasserts.
  - This prevents a spurious capture while the synchroniser fills from its reset value.
  - `prev_val` keeps tracking `sync_val` during blanking.
  - The counter saturates and holds at its terminal value.
- Read path: `readdata` is loaded every cycle from the address mux (no read strobe needed; chipselect is not required for reads). It is valid one cycle after `address` is presented.
- Write acceptance: a write takes effect only when `chipselect=1` and `write_n=0`.
- Reset values, all 0: sync chain, `prev_val`, `readdata`, IRQ_MASK, EDGE_CAPTURE, blanking counter. Hence `irq=0` during reset.
- Reset mid-operation: reset clears capture and mask immediately on that clock edge, drops `irq`, and restarts the blanking count. An in-flight read returns 0.
- Boundaries:
  - An input pulse shorter than one `clk` period may be missed; no capture is guaranteed for it.
  - A level held across multiple cycles produces exactly one capture per transition.

Test Plan:
- Reset, then read addresses 0, 2, 3 with `in_port=0` -> `readdata=0x0`, `irq=0` throughout.
- EDGE_TYPE=0, mask=0xF. Drive `in_port` 0x0 -> 0x5 at cycle N -> DATA reads 0x5 from cycle N+2. EDGE_CAPTURE=0x5 and `irq=1` from cycle N+3.
- With capture=0x5, write 0x1 to address 3 -> capture=0x4 and `irq` stays 1. Then write 0x4 -> capture=0x0 and `irq=0` the next cycle.
- Mask=0x0 while bit 1 rises -> capture=0x2 and `irq=0`. Then write mask=0x2 -> `irq=1` one cycle later.
- Same-cycle collision: bit 3 edge arrives in the cycle of a W1C write of 0x8 -> bit 3 still reads 1.
- Hold `in_port=0xF` through reset and release it -> no capture during blanking, EDGE_CAPTURE=0x0, and DATA reads 0xF after SYNC_STAGES cycles.
